// File: rtl/fp_div_pkg.sv
// Shared widths and FSM encoding for the sequential significand divider.
package fp_div_pkg;
    localparam int SIG_W = 24;
    localparam int Q_W   = 25;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/significand_div_seq_if.sv
// Request/result bundle between the decompose stage, the divider and the packing stage.
interface significand_div_seq_if;
    import fp_div_pkg::*;

    logic             start;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
    logic             busy;
    logic             done;
    logic [Q_W-1:0]   sig_div;
    logic             sticky;
    logic             div_by_zero;

    modport master (
        output start, sig_a, sig_b,
        input  busy, done, sig_div, sticky, div_by_zero
    );

    modport slave (
        input  start, sig_a, sig_b,
        output busy, done, sig_div, sticky, div_by_zero
    );
endinterface

// File: rtl/sig_div_step.sv
// One restoring-division step: compare, conditionally subtract, emit the quotient bit.
module sig_div_step
    import fp_div_pkg::*;
(
    input  logic [Q_W-1:0]   rem_i,
    input  logic [SIG_W-1:0] divisor_i,
    output logic             q_bit_o,
    output logic [Q_W-1:0]   rem_o
);
    logic           ge;
    logic [Q_W-1:0] diff;

    // A set rem MSB already exceeds any 24-bit divisor, so only the low bits need comparing.
    assign ge      = rem_i[Q_W-1] | (rem_i[SIG_W-1:0] >= divisor_i);
    assign diff    = rem_i - {1'b0, divisor_i};
    assign q_bit_o = ge;
    assign rem_o   = ge ? diff : rem_i;
endmodule

// File: rtl/significand_div_seq.sv
// Sequential restoring divider for FP significands: 25 quotient bits, one per clock, MSB first.
module significand_div_seq
    import fp_div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    significand_div_seq_if.slave bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Q_W-1:0]   rem_q, rem_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [Q_W-1:0]   res_q, res_d;
    logic [SIG_W-1:0] dvs_q, dvs_d;
    logic             sticky_q, sticky_d;
    logic             dbz_q, dbz_d;

    logic             step_bit;
    logic [Q_W-1:0]   step_rem;
    logic             accept;
    logic             b_zero;

    assign accept = (state_q == IDLE) && bus.start;
    assign b_zero = (bus.sig_b == '0);

    sig_div_step u_step (
        .rem_i     (rem_q),
        .divisor_i (dvs_q),
        .q_bit_o   (step_bit),
        .rem_o     (step_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = b_zero ? DONE : RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
    end

    // Working registers follow the FSM; result registers only move at completion.
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        res_d    = res_q;
        dvs_d    = dvs_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        if (accept) begin
            if (b_zero) begin
                dbz_d    = 1'b1;
                res_d    = '1;
                sticky_d = 1'b0;
            end else begin
                dbz_d = 1'b0;
                rem_d = {1'b0, bus.sig_a};
                dvs_d = bus.sig_b;
                cnt_d = CNT_W'(SIG_W);
                quo_d = '0;
            end
        end else if (state_q == RUN) begin
            quo_d = {quo_q[Q_W-2:0], step_bit};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                rem_d    = step_rem;
                res_d    = {quo_q[Q_W-2:0], step_bit};
                sticky_d = |step_rem;
            end else begin
                rem_d = {step_rem[Q_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            res_q    <= '0;
            dvs_q    <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            res_q    <= res_d;
            dvs_q    <= dvs_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.sig_div     = res_q;
    assign bus.sticky      = sticky_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_significand_div_seq.sv
// Randomised and directed checks of significand_div_seq against an arithmetic quotient model.
module tb_significand_div_seq;
    import fp_div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    significand_div_seq_if bus ();

    significand_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void ref_div(input logic [23:0] a, input logic [23:0] b,
                                    output logic [24:0] q, output logic s);
        longint unsigned n;
        n = {40'd0, a} << 24;
        q = 25'(n / {40'd0, b});
        s = (n % {40'd0, b}) != 0;
    endfunction

    // Present operands for one start edge; returns at the negedge after that edge.
    task automatic pulse_start(input logic [23:0] a, input logic [23:0] b);
        bus.start = 1'b1;
        bus.sig_a = a;
        bus.sig_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.sig_a = $urandom();
        bus.sig_b = $urandom();
    endtask

    // Counts edges from the start edge until done is seen (bounded).
    task automatic wait_done(output int k, output bit saw_busy, output bit overlap);
        k = 0; saw_busy = 0; overlap = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            if (bus.busy === 1'b1) saw_busy = 1;
            @(negedge clk);
            k++;
        end
        if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.sig_div, bus.sticky, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h s=%b dbz=%b, need all 0",
                     bus.busy, bus.done, bus.sig_div, bus.sticky, bus.div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [23:0] av [4] = '{24'hC00000, 24'h800000, 24'hFFFFFF, 24'h000000};
        logic [23:0] bv [4] = '{24'h800000, 24'hC00000, 24'hFFFFFF, 24'h9ABCDE};
        logic [24:0] qv [4] = '{25'h1800000, 25'h0AAAAAA, 25'h1000000, 25'h0000000};
        logic        sv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int k; bit sb, ov;
        for (int i = 0; i < 4; i++) begin
            pulse_start(av[i], bv[i]);
            wait_done(k, sb, ov);
            checks++;
            if (k != 25 || !sb || ov) begin
                errors++;
                $display("FAIL dir%0d_timing: got done after %0d edges busy_seen=%b overlap=%b, need 25/1/0",
                         i, k, sb, ov);
            end
            checks++;
            if (bus.sig_div !== qv[i] || bus.sticky !== sv[i] || bus.div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_result: got q=%h s=%b dbz=%b, need q=%h s=%b dbz=0",
                         i, bus.sig_div, bus.sticky, bus.div_by_zero, qv[i], sv[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sig_div !== qv[i] || bus.sticky !== sv[i]) begin
                errors++;
                $display("FAIL dir%0d_hold: got done=%b busy=%b q=%h s=%b, need 0/0/%h/%b",
                         i, bus.done, bus.busy, bus.sig_div, bus.sticky, qv[i], sv[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int k; bit sb, ov;
        logic [24:0] q; logic s;
        pulse_start(24'hABCDEF, 24'h000000);
        wait_done(k, sb, ov);
        checks++;
        if (k != 0 || sb || ov) begin
            errors++;
            $display("FAIL dbz_timing: got done after %0d edges busy_seen=%b, need 0 edges, busy 0", k, sb);
        end
        checks++;
        if (bus.div_by_zero !== 1'b1 || bus.sig_div !== 25'h1FFFFFF || bus.sticky !== 1'b0) begin
            errors++;
            $display("FAIL dbz_result: got dbz=%b q=%h s=%b, need 1/1ffffff/0",
                     bus.div_by_zero, bus.sig_div, bus.sticky);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold: got done=%b busy=%b dbz=%b, need 0/0/1", bus.done, bus.busy, bus.div_by_zero);
        end
        pulse_start(24'h900000, 24'hA00000);
        checks++;
        if (bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dbz_clear: got dbz=%b after good start, need 0", bus.div_by_zero);
        end
        wait_done(k, sb, ov);
        ref_div(24'h900000, 24'hA00000, q, s);
        checks++;
        if (k != 25 || bus.sig_div !== q || bus.sticky !== s) begin
            errors++;
            $display("FAIL dbz_followup: got k=%0d q=%h s=%b, need 25/%h/%b", k, bus.sig_div, bus.sticky, q, s);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int k; bit ov;
        pulse_start(24'hC00000, 24'h800000);
        k = 0; ov = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            if (k % 4 == 2) begin
                bus.start = 1'b1;
                bus.sig_a = {1'b1, 23'($urandom())};
                bus.sig_b = $urandom_range(1, 3) == 1 ? 24'h0 : {1'b1, 23'($urandom())};
            end else bus.start = 1'b0;
            @(negedge clk);
            k++;
        end
        bus.start = 1'b1; // also pulse during DONE
        checks++;
        if (k != 25 || bus.sig_div !== 25'h1800000 || bus.sticky !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run: got k=%0d q=%h s=%b dbz=%b, need 25/1800000/0/0",
                     k, bus.sig_div, bus.sticky, bus.div_by_zero);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done: got busy=%b done=%b after DONE-state start, need 0/0", bus.busy, bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int k; bit sb, ov, seen;
        pulse_start(24'hFEDCBA, 24'h876543);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.sig_div, bus.sticky, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b done=%b q=%h s=%b dbz=%b, need all 0",
                     bus.busy, bus.done, bus.sig_div, bus.sticky, bus.div_by_zero);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: got done/busy activity after abort=%b, need 0", seen);
        end
        pulse_start(24'hC00000, 24'h800000);
        wait_done(k, sb, ov);
        checks++;
        if (k != 25 || bus.sig_div !== 25'h1800000 || bus.sticky !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: got k=%0d q=%h s=%b, need 25/1800000/0", k, bus.sig_div, bus.sticky);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int k; bit sb, ov;
        logic [23:0] a, b;
        logic [24:0] q; logic s;
        for (int i = 0; i < 40; i++) begin
            a = (i % 10 == 9) ? 24'h0 : {1'b1, 23'($urandom())};
            b = {1'b1, 23'($urandom())};
            ref_div(a, b, q, s);
            pulse_start(a, b);
            wait_done(k, sb, ov);
            checks++;
            if (k != 25 || ov || bus.sig_div !== q || bus.sticky !== s || bus.div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h: got k=%0d q=%h s=%b dbz=%b, need 25/%h/%b/0",
                         i, a, b, k, bus.sig_div, bus.sticky, bus.div_by_zero, q, s);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int k; bit sb, ov;
        logic [24:0] q; logic s;
        pulse_start(24'hD00000, 24'hB00000);
        wait_done(k, sb, ov);
        // Held across DONE (ignored) and then accepted in IDLE.
        bus.start = 1'b1;
        bus.sig_a = 24'h812345;
        bus.sig_b = 24'hFEDCBA;
        @(negedge clk);
        pulse_start(24'h812345, 24'hFEDCBA);
        wait_done(k, sb, ov);
        ref_div(24'h812345, 24'hFEDCBA, q, s);
        checks++;
        if (k != 25 || bus.sig_div !== q || bus.sticky !== s) begin
            errors++;
            $display("FAIL b2b: got k=%0d q=%h s=%b, need 25/%h/%b", k, bus.sig_div, bus.sticky, q, s);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sig_a = '0;
        bus.sig_b = '0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/significand_div_seq.md
SIGNIFICAND_DIV_SEQ -- requirements
Module: SIGNIFICAND_DIV_SEQ

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 sig_a  input  24  dividend significand {hidden bit, fraction}, from the decompose stage.
REQ-005 sig_b  input  24  divisor significand, same format.
REQ-006 busy  output  1  high in RUN.
REQ-007 done  output  1  one-cycle pulse; sig_div, sticky and div_by_zero valid in that cycle.
REQ-008 sig_div  output  25  quotient, consumed by the result-packing stage.
REQ-009 sticky  output  1  final remainder non-zero (rounding input).
REQ-010 div_by_zero  output  1  sig_b was zero at start.

Function
REQ-011 The block SHALL compute sig_div = floor(sig_a * 2^24 / sig_b), truncated to 25 bits; for normalized operands sig_div[24]=1 iff sig_a >= sig_b, otherwise sig_div[23]=1.
REQ-012 The algorithm SHALL be restoring division, one quotient bit per cycle, MSB first:
  - 25-bit partial remainder, initialised to {1'b0, sig_a};
  - each step: if rem >= {1'b0, sig_b}, the quotient bit is 1 and rem = rem - sig_b, else the quotient bit is 0;
  - then rem = rem << 1 (except after the last step).
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
  - IDLE -> RUN on start=1 with sig_b != 0: latch operands, bit counter = 24.
  - RUN: one step per edge, counter decrements; RUN -> DONE on the edge that processes counter = 0.
  - DONE -> IDLE unconditionally after one cycle.
REQ-014 Latency: with start sampled at edge N, done SHALL be high during the cycle following edge N+25 (25 RUN edges), and low at all other times.
REQ-015 start SHALL be ignored in RUN and in DONE; operand changes after the start edge SHALL NOT affect the result.
REQ-016 On start=1 with sig_b == 0, the FSM SHALL go IDLE -> DONE directly with:
  - div_by_zero = 1;
  - sig_div = 25'h1FFFFFF;
  - sticky = 0.
REQ-017 sig_a == 0 SHALL run the normal 25 cycles and produce sig_div = 0 and sticky = 0.
REQ-018 sticky SHALL be 1 iff the remainder after the final step is non-zero.
REQ-019 sig_div, sticky and div_by_zero SHALL hold their values from done until the next accepted start; div_by_zero SHALL clear on a start with sig_b != 0.
REQ-020 busy SHALL be 1 exactly in RUN; busy and done SHALL never be high together.

Reset
REQ-021 rst_n low SHALL immediately force:
  - state IDLE;
  - busy = 0, done = 0;
  - sig_div = 0, sticky = 0, div_by_zero = 0;
  - counter and remainder cleared.
REQ-022 Reset asserted during RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL be processed normally.

Structure
REQ-023 Package FP_DIV_PKG SHALL hold:
  - SIG_W = 24, Q_W = 25, CNT_W = 5;
  - the FSM state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2).
REQ-024 One combinational sub-module, SIG_DIV_STEP, SHALL implement a single restoring step.
  - Inputs: rem, divisor.
  - Outputs: quotient bit, next rem.
  - Built from the existing 24-bit comparator/subtractor primitives.
  - Instantiated once; the step logic SHALL NOT be unrolled.

Verification
REQ-025 sig_a=24'hC00000, sig_b=24'h800000, start -> after 25 RUN cycles: done=1, sig_div=25'h1800000, sticky=0.
REQ-026 sig_a=24'h800000, sig_b=24'hC00000 -> sig_div=25'h0AAAAAA, sticky=1.
REQ-027 sig_a=sig_b=24'hFFFFFF -> sig_div=25'h1000000, sticky=0; done exactly 26 cycles after the start edge.
REQ-028 sig_b=0 with start -> done the next cycle, div_by_zero=1, sig_div=25'h1FFFFFF, busy never high.
REQ-029 Start pulses with different operands during RUN -> ignored; the first result is unchanged.
REQ-030 rst_n low at RUN cycle 10 -> all outputs 0 immediately, no done; a new start after release (sig_a=24'hC00000, sig_b=24'h800000) -> correct result.
